sort_oet_seq: RTL and testbench
===============================

// Module: sort_oet_seq
// PURPOSE
// - Sequential, parametrised sorter: accepts N unsigned W-bit keys in one
//   handshake and sorts them by odd-even transposition, one phase per clock.
// - Runtime ascending/descending mode and early termination once sorted.
// - Drives the sorted vector out with a valid/ready handshake.
// - Sits between a packed-vector producer and a consumer; replaces the
//   combinational 4-key sort task where timing or N make that impractical.
// PARAMETERS
// - W   4  key width in bits, >= 1
// - N   4  number of keys, >= 2 (odd N supported)
// - CW  $clog2(N+1)  phase-counter width (derived localparam, not overridable)
// PORTS
// - clk        in   1     single clock, rising edge
// - rst_n      in   1     asynchronous, active-low reset
// - in_valid   in   1     in_data/in_desc valid
// - in_ready   out  1     sorter idle, can accept a vector
// - in_data    in   N*W   key k at bits [k*W +: W]
// - in_desc    in   1     1 = descending, 0 = ascending; sampled with in_data
// - out_valid  out  1     out_data holds the sorted vector
// - out_ready  in   1     consumer accepts out_data
// - out_data   out  N*W   sorted; key k at [k*W +: W]; key 0 smallest (asc)
// - out_phases out  CW    phases executed for this vector, 1..N
// - busy       out  1     high in SORT
// BEHAVIOUR
// - Reset (async assert, sync deassert by the system):
//   - state=IDLE; in_ready=1; out_valid=0; busy=0.
//   - out_data=0; out_phases=0; internal key regs=0.
// - FSM states and transitions:
//   - IDLE: in_ready=1. in_valid&in_ready -> load keys and mode, phase=0,
//     -> SORT.
//   - SORT: each cycle performs one phase.
//     - Even phase compares pairs (0,1),(2,3),...; odd phase compares
//       pairs (1,2),(3,4),...
//     - Swap only on strict '>' (asc) or '<' (desc); equal keys never
//       swap, so the sort is stable.
//     - phase increments each cycle.
//     - Exit to DONE after N phases, or earlier after two consecutive
//       phases with zero swaps.
//   - DONE: out_valid=1. out_ready -> IDLE next cycle.
// - Latency: load->out_valid = phases+1 cycles; worst case N+1, best 3.
// - Handshakes:
//   - in_ready=0 outside IDLE; in_valid while busy is ignored, not queued.
//   - out_data and out_phases stay stable while out_valid & !out_ready.
//   - No same-cycle bypass: after an out accept, in_ready rises the
//     following cycle.
// - Arithmetic: unsigned compare, full W bits; no saturation, no
//   widening.
// - Boundaries:
//   - N=2: only even phases swap.
//   - Odd N: the last key is unpaired in even phases, the first key in
//     odd phases.
//   - Already-sorted input: exactly 2 phases.
//   - All-equal keys: 2 phases, output equals input.
//   - Reset mid-SORT or mid-DONE: immediate IDLE, the pending vector is
//     discarded, outputs return to reset values.
//   - in_desc changes after load: no effect until the next load.
// STRUCTURE
// - Package sort_pkg:
//   - state enum {S_IDLE, S_SORT, S_DONE}
//   - function pair_base(phase) returning 0/1
// - Sub-module sort_cmp_swap (W):
//   - inputs: lo, hi, desc
//   - outputs: lo_o, hi_o, swapped
//   - combinational; instantiated N/2 times on a shared network, muxed
//     by phase parity.
// - Top holds the FSM, key register array, phase counter and swap-history
//   bit.
// TESTING
// - Reset: W=4,N=4, drive in_valid during rst_n=0 -> in_ready=1,
//   out_valid=0, out_data=0.
// - Ascending: in {k0..k3}={9,3,7,1}, desc=0 -> out {1,3,7,9};
//   out_valid 5 cycles after accept; out_phases=4.
// - Descending, early exit: {1,2,3,4}, desc=1 -> {4,3,2,1};
//   sorted input {9,7,3,1}, desc=1 -> phases=2, out_valid 3 cycles after
//   accept.
// - Backpressure: hold out_ready=0 for 10 cycles -> out_data stable,
//   in_ready=0, in_valid pulses ignored. After accept, in_ready=1 the
//   next cycle.
// - Odd N and equal keys: N=5,W=8, {5,5,0,255,5} asc -> {0,5,5,5,255}.
//   Tag equal keys via a parallel-stable check model -> original order
//   kept.
// - Reset mid-sort: assert rst_n=0 two cycles into SORT -> state IDLE,
//   busy=0. The next vector {2,1,4,3} sorts to {1,2,3,4} unaffected.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state type and phase helper for the odd-even transposition sorter
package sort_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_t;
  function automatic logic pair_base(input int unsigned phase);
    return (phase & 1) != 0;
  endfunction
endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: one compare-exchange cell; swaps only on strict order violation
module sort_cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic         desc,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o,
  output logic         swapped
);
  assign swapped = desc ? (lo < hi) : (lo > hi);
  assign lo_o = swapped ? hi : lo;
  assign hi_o = swapped ? lo : hi;
endmodule

// File: rtl/sort_oet_seq.sv
// sort_oet_seq: sequential odd-even transposition sorter, one phase per clock,
// early exit after two consecutive swap-free phases
module sort_oet_seq
  import sort_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [CW-1:0]  out_phases,
  output logic           busy
);
  state_t state, state_n;
  logic [W-1:0] k [N];
  logic [W-1:0] nk [N];
  logic [W-1:0] lo_i [N/2];
  logic [W-1:0] hi_i [N/2];
  logic [W-1:0] lo_o [N/2];
  logic [W-1:0] hi_o [N/2];
  logic [N/2-1:0] sw;
  logic [CW-1:0] phase;
  logic desc, hist, fin, b, quiet;
  assign b = pair_base(32'(phase));
  assign quiet = ~|sw;
  // odd phases reuse the same cells; an out-of-range odd pair compares a key with itself
  for (genvar i = 0; i < N/2; i++) begin : g_cmp
    localparam int OH = (2*i + 2 < N) ? 2*i + 2 : 2*i + 1;
    assign lo_i[i] = b ? k[2*i+1] : k[2*i];
    assign hi_i[i] = b ? k[OH] : k[2*i+1];
    sort_cmp_swap #(.W(W)) u_cs (
      .lo(lo_i[i]),
      .hi(hi_i[i]),
      .desc(desc),
      .lo_o(lo_o[i]),
      .hi_o(hi_o[i]),
      .swapped(sw[i])
    );
  end
  for (genvar j = 0; j < N; j++) begin : g_key
    logic [W-1:0] ev, od;
    if (j % 2 == 0 && j + 1 < N) begin : g_ev_lo
      assign ev = lo_o[j/2];
    end else if (j % 2 == 1) begin : g_ev_hi
      assign ev = hi_o[j/2];
    end else begin : g_ev_keep
      assign ev = k[j];
    end
    if (j % 2 == 1 && j + 1 < N) begin : g_od_lo
      assign od = lo_o[j/2];
    end else if (j % 2 == 0 && j > 0) begin : g_od_hi
      assign od = hi_o[(j-1)/2];
    end else begin : g_od_keep
      assign od = k[j];
    end
    assign nk[j] = b ? od : ev;
    assign out_data[j*W +: W] = k[j];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= '0;
      desc  <= 1'b0;
      hist  <= 1'b0;
      fin   <= 1'b0;
      for (int j = 0; j < N; j++) k[j] <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && in_valid) begin
        for (int j = 0; j < N; j++) k[j] <= in_data[j*W +: W];
        desc  <= in_desc;
        phase <= '0;
        hist  <= 1'b0;
        fin   <= 1'b0;
      end else if (state == S_SORT && !fin) begin
        for (int j = 0; j < N; j++) k[j] <= nk[j];
        phase <= phase + 1'b1;
        hist  <= quiet;
        fin   <= (phase == CW'(N - 1)) || (hist && quiet);
      end
    end
  end
  // the exit decision is registered, so DONE follows the last phase by one cycle
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE && in_valid)  ? S_SORT :
              (state == S_SORT && fin)       ? S_DONE :
              (state == S_DONE && out_ready) ? S_IDLE : state;
  end
  assign in_ready   = state == S_IDLE;
  assign out_valid  = state == S_DONE;
  assign busy       = state == S_SORT;
  assign out_phases = phase;
endmodule

// File: tb/tb_sort_oet_seq.sv
// tb_sort_oet_seq: scoreboard bench for the sequential odd-even sorter (N=4 and N=5 instances)
module tb_sort_oet_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_desc = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [15:0] in_data = '0, out_data;
  logic [2:0] out_phases;
  logic v5 = 1'b0, desc5 = 1'b0, ordy5 = 1'b0;
  logic r5, ov5, b5;
  logic [39:0] id5 = '0, od5;
  logic [2:0] op5;
  int tests = 0;
  int fails = 0;
  typedef struct { logic [15:0] d; logic [2:0] ph; } exp_t;
  exp_t sb[$];

  sort_oet_seq #(.W(4), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_phases(out_phases), .busy(busy)
  );
  sort_oet_seq #(.W(8), .N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5),
    .in_data(id5), .in_desc(desc5), .out_valid(ov5),
    .out_ready(ordy5), .out_data(od5), .out_phases(op5), .busy(b5)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // stable insertion sort gives the data; a plain OET run gives the phase count
  function automatic void model(input int a[8], input int n, input bit desc,
                                output int s[8], output int ph);
    int t[8];
    int v, j;
    bit q, pq;
    s = a;
    for (int i = 1; i < n; i++) begin
      v = s[i];
      j = i;
      while (j > 0 && (desc ? s[j-1] < v : s[j-1] > v)) begin
        s[j] = s[j-1];
        j--;
      end
      s[j] = v;
    end
    t = a;
    pq = 1'b0;
    ph = 0;
    for (int p = 0; p < n; p++) begin
      q = 1'b1;
      for (int i = p % 2; i + 1 < n; i += 2)
        if (desc ? t[i] < t[i+1] : t[i] > t[i+1]) begin
          v = t[i]; t[i] = t[i+1]; t[i+1] = v; q = 1'b0;
        end
      ph = p + 1;
      if (pq && q) break;
      pq = q;
    end
  endfunction

  task automatic send4(input int a[8], input bit desc);
    int s[8];
    int ph;
    exp_t e;
    model(a, 4, desc, s, ph);
    for (int j = 0; j < 4; j++) begin
      e.d[j*4 +: 4] = s[j][3:0];
      in_data[j*4 +: 4] = a[j][3:0];
    end
    e.ph = 3'(ph);
    sb.push_back(e);
    in_desc = desc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_desc = ~desc;
  endtask

  task automatic recv4(input string name);
    exp_t e;
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cyc);
    end
    tests++;
    if (cyc !== int'(e.ph) + 1) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, int'(e.ph) + 1);
    end
    tests++;
    if (out_data !== e.d) begin
      fails++;
      $display("FAIL %s data: got %h, required %h", name, out_data, e.d);
    end
    tests++;
    if (out_phases !== e.ph) begin
      fails++;
      $display("FAIL %s phases: got %0d, required %0d", name, out_phases, e.ph);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s in_ready_done: got %b, required 0", name, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s after_accept: in_ready=%b out_valid=%b, required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    in_data = 16'h1234;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1/0/0", in_ready, out_valid, busy);
    end
    tests++;
    if (out_data !== 16'h0 || out_phases !== 3'd0) begin
      fails++;
      $display("FAIL reset_data: out_data=%h out_phases=%0d, required 0/0", out_data, out_phases);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_ascending;
    int a[8] = '{9, 3, 7, 1, 0, 0, 0, 0};
    send4(a, 1'b0);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL asc_busy: busy=%b in_ready=%b, required 1/0", busy, in_ready);
    end
    recv4("asc");
  endtask

  task automatic test_descending;
    int a[8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    int c[8] = '{9, 7, 3, 1, 0, 0, 0, 0};
    send4(a, 1'b1);
    recv4("desc");
    send4(c, 1'b1);
    recv4("desc_sorted");
  endtask

  task automatic test_back_to_back;
    int a[8];
    int e[8] = '{6, 6, 6, 6, 0, 0, 0, 0};
    send4(e, 1'b0);
    recv4("all_equal");
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 4; j++) a[j] = int'($urandom_range(0, 15));
      send4(a, n[0]);
      recv4("random4");
    end
  endtask

  task automatic test_backpressure;
    int a[8] = '{5, 0, 15, 8, 0, 0, 0, 0};
    exp_t e;
    int cyc = 0;
    send4(a, 1'b0);
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_valid: out_valid=%b, required 1", out_valid);
    end
    for (int n = 0; n < 10; n++) begin
      in_valid = n[0];
      in_data = 16'hfedc;
      @(posedge clk); #1;
      tests++;
      if (out_data !== e.d || out_phases !== e.ph || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: data=%h ph=%0d valid=%b in_ready=%b, required %h/%0d/1/0",
                 n, out_data, out_phases, out_valid, in_ready, e.d, e.ph);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready_next: in_ready=%b, required 1", in_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_not_queued: out_valid=%b busy=%b, required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_odd_n;
    int a[8];
    int s[8];
    int ph, cyc;
    logic [39:0] ed;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) a = '{5, 5, 0, 255, 5, 0, 0, 0};
      else for (int j = 0; j < 5; j++) a[j] = int'($urandom_range(0, 3)) * 85;
      model(a, 5, n[0] && n > 0, s, ph);
      for (int j = 0; j < 5; j++) begin
        ed[j*8 +: 8] = s[j][7:0];
        id5[j*8 +: 8] = a[j][7:0];
      end
      desc5 = n[0] && n > 0;
      v5 = 1'b1;
      @(posedge clk); #1;
      v5 = 1'b0;
      cyc = 0;
      while (!ov5 && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      tests++;
      if (od5 !== ed || op5 !== 3'(ph) || cyc !== ph + 1) begin
        fails++;
        $display("FAIL odd_n vec %0d: data=%h ph=%0d lat=%0d, required %h/%0d/%0d",
                 n, od5, op5, cyc, ed, ph, ph + 1);
      end
      ordy5 = 1'b1;
      @(posedge clk); #1;
      ordy5 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sort;
    int a[8] = '{9, 3, 7, 1, 0, 0, 0, 0};
    int c[8] = '{2, 1, 4, 3, 0, 0, 0, 0};
    send4(a, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_phases !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b in_ready=%b out_valid=%b data=%h ph=%0d, required 0/1/0/0/0",
               busy, in_ready, out_valid, out_data, out_phases);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send4(c, 1'b0);
    recv4("after_reset");
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_backpressure();
    test_back_to_back();
    test_odd_n();
    test_reset_mid_sort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
